// File: rtl/exa_credit_tx.sv
// exa_credit_tx: transmit side of the credit-based link. Drains packets from a local
// first-word-fall-through FIFO and forwards them word by word to a remote FIFO. A packet's
// header is popped only when the credit count covers the whole packet. All of its credits
// are reserved up front, so body words then flow without any further credit check.
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   i_fifo_empty       local FIFO empty
//   i_fifo_data        local FIFO head word (valid while not empty)
//   o_fifo_rd_en       pop local FIFO (combinational)
//   o_tx_valid/data    registered link word
//   o_tx_sop/eop       registered header / last-word flags
//   i_credit_ret       remote freed one word (+1 credit)
//   o_credits          current credit count
//   o_busy             packet body in progress
//   o_err_ovf          sticky: credit returned while already at CREDITS
module exa_credit_tx #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned CREDITS = 16,
  parameter int unsigned LEN_LSB = 0,
  parameter int unsigned LEN_W   = 4,
  localparam int unsigned CW     = $clog2(CREDITS) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_fifo_empty,
  input  logic [DWIDTH-1:0] i_fifo_data,
  output logic              o_fifo_rd_en,
  output logic              o_tx_valid,
  output logic [DWIDTH-1:0] o_tx_data,
  output logic              o_tx_sop,
  output logic              o_tx_eop,
  input  logic              i_credit_ret,
  output logic [CW-1:0]     o_credits,
  output logic              o_busy,
  output logic              o_err_ovf
);

  // The longest possible packet must fit in the remote FIFO, otherwise it could never start.
  if ((1 << LEN_W) - 1 > CREDITS) begin : g_len_check
    $error("exa_credit_tx: maximum packet length exceeds CREDITS");
  end

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              err_q, err_d;
  logic              tx_valid_q, tx_sop_q, tx_eop_q;
  logic [DWIDTH-1:0] tx_data_q;

  logic [LEN_W-1:0]  len_field;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_fits;
  logic              rd_en;
  logic              sop, eop;

  always_comb begin
    len_field = i_fifo_data[LEN_LSB +: LEN_W];
    // A zero length field still denotes the header-only packet.
    hdr_len   = (len_field == '0) ? LEN_W'(1) : len_field;
    // Decision uses the registered count only; a same-cycle return does not help.
    hdr_fits  = (credits_q >= CW'(hdr_len));
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    sop     = 1'b0;
    eop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_fifo_empty && hdr_fits) begin
          rd_en = 1'b1;
          sop   = 1'b1;
          if (hdr_len == LEN_W'(1)) begin
            eop = 1'b1;
          end else begin
            rem_d   = hdr_len - LEN_W'(1);
            state_d = StBody;
          end
        end
      end
      StBody: begin
        if (!i_fifo_empty) begin
          rd_en = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            eop     = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (rd_en && (state_q == StIdle)) begin
      // Whole-packet reservation; a return in the same cycle is folded in.
      credits_d = credits_q - CW'(hdr_len) + CW'(i_credit_ret);
    end else if (i_credit_ret) begin
      if (credits_q == CW'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      credits_q  <= CW'(CREDITS);
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      credits_q  <= credits_d;
      err_q      <= err_d;
      tx_valid_q <= rd_en;
      tx_sop_q   <= sop;
      tx_eop_q   <= eop;
      if (rd_en) begin
        tx_data_q <= i_fifo_data;
      end
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_sop     = tx_sop_q;
  assign o_tx_eop     = tx_eop_q;
  assign o_credits    = credits_q;
  assign o_busy       = (state_q == StBody);
  assign o_err_ovf    = err_q;

endmodule

// File: tb/tb_exa_credit_tx.sv
module tb_exa_credit_tx;

  localparam int unsigned DWIDTH  = 32;
  localparam int unsigned CREDITS = 16;
  localparam int unsigned CW      = $clog2(CREDITS) + 1;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              i_fifo_empty;
  logic [DWIDTH-1:0] i_fifo_data;
  logic              o_fifo_rd_en;
  logic              o_tx_valid;
  logic [DWIDTH-1:0] o_tx_data;
  logic              o_tx_sop;
  logic              o_tx_eop;
  logic              i_credit_ret;
  logic [CW-1:0]     o_credits;
  logic              o_busy;
  logic              o_err_ovf;

  exa_credit_tx #(
    .DWIDTH (DWIDTH),
    .CREDITS(CREDITS),
    .LEN_LSB(0),
    .LEN_W  (4)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data (i_fifo_data),
    .o_fifo_rd_en(o_fifo_rd_en),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .o_tx_sop    (o_tx_sop),
    .o_tx_eop    (o_tx_eop),
    .i_credit_ret(i_credit_ret),
    .o_credits   (o_credits),
    .o_busy      (o_busy),
    .o_err_ovf   (o_err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DWIDTH-1:0] data;
    bit                hdr;
    bit                eop;
    int unsigned       len;
  } word_t;

  // Reference model: local FIFO contents, expected link words, credit ledger.
  word_t       fifoq[$];
  word_t       exp_q[$];
  int unsigned mc;
  bit          ovf;
  bit          mid_pkt;
  bit          force_ret;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_packet();
    int unsigned f;
    int unsigned len;
    logic [31:0] r;
    word_t       w;
    f   = $urandom_range(0, 15);
    len = (f == 0) ? 1 : f;
    for (int i = 0; i < int'(len); i++) begin
      r      = $urandom();
      w.data = (i == 0) ? {r[31:4], 4'(f)} : r;
      w.hdr  = (i == 0);
      w.eop  = (i == int'(len) - 1);
      w.len  = len;
      fifoq.push_back(w);
    end
  endtask

  // One clock cycle of stimulus, cycle-level checks and model update.
  task automatic run_cycles(input int n, input bit refill);
    bit    stall, ret, exp_pop;
    word_t w;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (refill && fifoq.size() < 20 && ($urandom_range(0, 1) == 1)) gen_packet();
      stall        = ($urandom_range(0, 4) == 0);
      i_fifo_empty = (fifoq.size() == 0) || stall;
      i_fifo_data  = (fifoq.size() != 0) ? fifoq[0].data : '0;
      // Remote only frees words it actually holds, unless an overflow is being provoked.
      ret          = force_ret || ((mc < CREDITS) && ($urandom_range(0, 2) == 0));
      i_credit_ret = ret;
      if (i_fifo_empty)     exp_pop = 1'b0;
      else if (fifoq[0].hdr) exp_pop = (mc >= fifoq[0].len);
      else                   exp_pop = 1'b1;
      #1;
      chk("rd_en", 64'(o_fifo_rd_en), 64'(exp_pop));
      chk("credits", 64'(o_credits), 64'(mc));
      chk("err_ovf", 64'(o_err_ovf), 64'(ovf));
      chk("busy", 64'(o_busy), 64'(mid_pkt));
      @(posedge clk);
      if (exp_pop) begin
        w = fifoq.pop_front();
        exp_q.push_back(w);
        mid_pkt = !w.eop;
      end
      if (exp_pop && w.hdr) begin
        mc = mc - w.len + (ret ? 1 : 0);
      end else if (ret) begin
        if (mc == CREDITS) ovf = 1'b1;
        else mc++;
      end
    end
  endtask

  task automatic model_reset();
    fifoq.delete();
    exp_q.delete();
    mc      = CREDITS;
    ovf     = 1'b0;
    mid_pkt = 1'b0;
  endtask

  // Monitor: every link word must be the next expected one.
  always @(negedge clk) begin
    word_t e;
    if (arst_n && o_tx_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got data 0x%0h, expected no word at %0t", o_tx_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("tx_word", 64'({o_tx_data, o_tx_sop, o_tx_eop}), 64'({e.data, e.hdr, e.eop}));
      end
    end
  end

  initial begin
    bit drained;
    force_ret    = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    i_credit_ret = 1'b0;
    arst_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_credits", 64'(o_credits), 64'(CREDITS));
    chk("rst_valid", 64'(o_tx_valid), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_err", 64'(o_err_ovf), 64'(0));
    arst_n = 1'b1;

    run_cycles(800, 1'b1);

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    i_fifo_empty = 1'b1;
    i_credit_ret = 1'b0;
    arst_n       = 1'b0;
    #1;
    chk("mid_rst_credits", 64'(o_credits), 64'(CREDITS));
    chk("mid_rst_valid", 64'(o_tx_valid), 64'(0));
    chk("mid_rst_busy", 64'(o_busy), 64'(0));
    chk("mid_rst_err", 64'(o_err_ovf), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    run_cycles(800, 1'b1);

    // Drain everything and let all credits come home.
    drained = 1'b0;
    for (int i = 0; i < 600 && !drained; i++) begin
      run_cycles(1, 1'b0);
      drained = (fifoq.size() == 0) && (mc == CREDITS) && !mid_pkt;
    end
    tests++;
    if (!drained) begin
      fails++;
      $display("FAIL drain: got %0d words left, credits %0d, expected 0 words and %0d credits",
               fifoq.size(), mc, CREDITS);
    end
    run_cycles(2, 1'b0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

    // Credit return while full: count saturates, sticky error sets.
    force_ret = 1'b1;
    run_cycles(1, 1'b0);
    force_ret = 1'b0;
    run_cycles(5, 1'b0);
    chk("ovf_sticky", 64'(o_err_ovf), 64'(1));
    chk("ovf_credits", 64'(o_credits), 64'(CREDITS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
